uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, LSB-first data, optional parity, stop bits.
// Line output is registered and idles high; one word accepted per frame.
module uart_tx #(
  parameter int p_BITSLOT_HALF_PERIOD = 1,
  parameter int p_DATA_BITS           = 8,
  parameter int p_STOP_BITS           = 1,
  parameter int p_PARITY              = 0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [p_DATA_BITS-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int SLOT = 2 * p_BITSLOT_HALF_PERIOD;
  localparam int CW   = $clog2(SLOT);
  localparam int BMAX = (p_DATA_BITS > p_STOP_BITS) ?
                        p_DATA_BITS : p_STOP_BITS;
  localparam int BW   = $clog2(BMAX + 1);
  localparam logic PODD = (p_PARITY == 1);
  localparam logic PEN  = (p_PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [p_DATA_BITS-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   slot_end;

  assign slot_end = (cnt_q == CW'(SLOT - 1));
  assign o_ready  = (state_q == S_IDLE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_tx     = tx_q;

  // Next state, next line level and counter updates; tx_d tracks state_d.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_valid) begin
          state_d = S_START;
          tx_d    = 1'b0;
          shift_d = i_data;
          par_d   = (^i_data) ^ PODD;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (slot_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (slot_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          tx_d    = shift_d[0];
          if (bit_q == BW'(p_DATA_BITS - 1)) begin
            bit_d = '0;
            if (PEN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (slot_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        tx_d  = 1'b1;
        if (slot_end) begin
          cnt_d = '0;
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(p_STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule
